// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one-at-a-time word reads to
// instruction memory and buffers returned words, PC-tagged, in a prefetch FIFO.
module instr_fetch_unit #(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0]      RESET_PC   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(3'b100);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   fetch_pc_r, fetch_pc_s;
    logic               mem_req_r, mem_req_s;
    logic [WIDTH-1:0]   mem_addr_r, mem_addr_s;
    logic [WIDTH-1:0]   target_aligned_s;
    logic               push_s;
    logic               pop_s;

    logic [WIDTH-1:0]   ir_mem_r [FIFO_DEPTH];
    logic [WIDTH-1:0]   pc_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic               ir_valid_r, ir_valid_s;
    logic [WIDTH-1:0]   ir_out_r, ir_out_s;
    logic [WIDTH-1:0]   pc_out_r, pc_out_s;

    // Low target bits are defined as don't-care; collapsed here so they are visibly consumed.
    logic               unused_target_bits_s;
    assign unused_target_bits_s = ^branch_target[1:0];
    assign target_aligned_s     = {branch_target[WIDTH-1:2], 2'b00};

    // Fetch FSM and fetch-PC state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
        end
    end

    // Fetch FSM next state: a started handshake is always carried to its ack, even after a redirect.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        push_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (branch_en) begin
                    fetch_pc_s = target_aligned_s;
                    state_s    = IDLE;
                end else if (count_r < DEPTH_C) begin
                    state_s    = WAIT;
                    mem_req_s  = 1'b1;
                    mem_addr_s = fetch_pc_r;
                end else begin
                    state_s    = IDLE;
                end
            end
            WAIT: begin
                if (branch_en) begin
                    fetch_pc_s = target_aligned_s;
                    if (mem_ack) begin
                        state_s   = IDLE;
                        mem_req_s = 1'b0;
                    end else begin
                        state_s   = DROP;
                    end
                end else if (mem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_s = fetch_pc_r + PC_STEP;
                    state_s    = IDLE;
                    mem_req_s  = 1'b0;
                end else begin
                    state_s    = WAIT;
                end
            end
            DROP: begin
                if (branch_en) begin
                    fetch_pc_s = target_aligned_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
                if (mem_ack) begin
                    state_s   = IDLE;
                    mem_req_s = 1'b0;
                end else begin
                    state_s   = DROP;
                end
            end
            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    assign pop_s = ir_valid_r && ir_ready && !branch_en;

    // FIFO pointer and occupancy update; a redirect flushes and overrides push/pop.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (branch_en) begin
            wr_ptr_s = PTR_ZERO;
            rd_ptr_s = PTR_ZERO;
            count_s  = CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    wr_ptr_s = wr_ptr_r + PTR_ONE;
                    count_s  = count_r + CNT_ONE;
                end
                2'b01: begin
                    rd_ptr_s = rd_ptr_r + PTR_ONE;
                    count_s  = count_r - CNT_ONE;
                end
                2'b11: begin
                    wr_ptr_s = wr_ptr_r + PTR_ONE;
                    rd_ptr_s = rd_ptr_r + PTR_ONE;
                end
                default: begin
                    count_s  = count_r;
                end
            endcase
        end
    end

    // Next head entry, so the consumer-facing outputs can be registered without extra latency.
    always_comb begin
        ir_valid_s = 1'b0;
        ir_out_s   = ZERO_W;
        pc_out_s   = ZERO_W;
        if (count_s != CNT_ZERO) begin
            ir_valid_s = 1'b1;
            if (push_s && (wr_ptr_r == rd_ptr_s)) begin
                ir_out_s = mem_rdata;
                pc_out_s = fetch_pc_r;
            end else begin
                ir_out_s = ir_mem_r[rd_ptr_s];
                pc_out_s = pc_mem_r[rd_ptr_s];
            end
        end else begin
            ir_valid_s = 1'b0;
        end
    end

    // FIFO control state and registered head outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            ir_valid_r <= 1'b0;
            ir_out_r   <= ZERO_W;
            pc_out_r   <= ZERO_W;
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            ir_valid_r <= ir_valid_s;
            ir_out_r   <= ir_out_s;
            pc_out_r   <= pc_out_s;
        end
    end

    // FIFO storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            ir_mem_r[wr_ptr_r] <= mem_rdata;
            pc_mem_r[wr_ptr_r] <= fetch_pc_r;
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign ir_valid = ir_valid_r;
    assign ir_out   = ir_out_r;
    assign pc_out   = pc_out_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; a second instance covers
// the PC wrap with RESET_PC near the top of the address space.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        branch_en;
    logic [31:0] branch_target;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_ir_out;
    logic [31:0] w_pc_out;
    logic        w_ir_valid;

    logic        auto_mem;
    int          n_cmp;
    int          n_err;

    instr_fetch_unit #(.WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_out(ir_out), .pc_out(pc_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .branch_en(branch_en), .branch_target(branch_target)
    );

    instr_fetch_unit #(.WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
        .ir_out(w_ir_out), .pc_out(w_pc_out), .ir_valid(w_ir_valid), .ir_ready(ir_ready),
        .branch_en(branch_en), .branch_target(branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; inputs updated 1 time unit after the edge; zero-wait memory when auto_mem is set.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_ack   = mem_req;
            mem_rdata = 32'hA000_0000 + mem_addr;
        end
        w_ack   = w_req;
        w_rdata = 32'hA000_0000 + w_addr;
    endtask

    task automatic do_reset();
        auto_mem      = 1'b1;
        reset         = 1'b1;
        branch_en     = 1'b0;
        branch_target = 32'h0;
        ir_ready      = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", ir_valid); end
        n_cmp++; if (ir_out !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h expected 00000000", ir_out); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 00000000", pc_out); end
        n_cmp++; if (w_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL reset_wrap_addr: got %h expected fffffff8", w_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        do_reset();
        ir_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (i % 2 == 1) begin
                pc = 32'((i - 1) / 2 * 4);
                n_cmp++; if (mem_req !== 1'b1 || mem_addr !== pc) begin n_err++; $display("FAIL zw_req c%0d: got req=%b addr=%h expected req=1 addr=%h", i, mem_req, mem_addr, pc); end
                n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL zw_idle_valid c%0d: got %b expected 0", i, ir_valid); end
            end else begin
                pc = 32'((i / 2 - 1) * 4);
                n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL zw_gap c%0d: got req=%b expected 0", i, mem_req); end
                n_cmp++; if (ir_valid !== 1'b1 || pc_out !== pc || ir_out !== (32'hA000_0000 | pc)) begin
                    n_err++; $display("FAIL zw_deliver c%0d: got v=%b pc=%h ir=%h expected v=1 pc=%h ir=%h", i, ir_valid, pc_out, ir_out, pc, 32'hA000_0000 | pc);
                end
            end
        end
    endtask

    task automatic test_full();
        int nreq;
        do_reset();
        nreq = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (mem_req === 1'b1 && i % 2 == 1) begin
                n_cmp++; if (mem_addr !== 32'(nreq * 4)) begin n_err++; $display("FAIL full_addr c%0d: got %h expected %h", i, mem_addr, 32'(nreq * 4)); end
                nreq++;
            end
        end
        n_cmp++; if (nreq !== 4) begin n_err++; $display("FAIL full_nreq: got %0d expected 4", nreq); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_req_low: got %b expected 0", mem_req); end
        n_cmp++; if (ir_valid !== 1'b1 || ir_out !== 32'hA000_0000 || pc_out !== 32'h0) begin
            n_err++; $display("FAIL full_head: got v=%b ir=%h pc=%h expected v=1 ir=a0000000 pc=00000000", ir_valid, ir_out, pc_out);
        end
        ir_ready = 1'b1;
        cycle();
        n_cmp++; if (ir_out !== 32'hA000_0004 || pc_out !== 32'h4 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL full_pop: got ir=%h pc=%h req=%b expected ir=a0000004 pc=00000004 req=0", ir_out, pc_out, mem_req);
        end
        ir_ready = 1'b0;
        cycle();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            n_err++; $display("FAIL full_refill: got req=%b addr=%h expected req=1 addr=00000010", mem_req, mem_addr);
        end
    endtask

    task automatic test_branch_idle();
        do_reset();
        for (int i = 1; i <= 6; i++) cycle();
        n_cmp++; if (ir_valid !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL bi_pre: got v=%b req=%b expected v=1 req=0", ir_valid, mem_req); end
        branch_en     = 1'b1;
        branch_target = 32'h103;
        cycle();
        branch_en = 1'b0;
        ir_ready  = 1'b1;
        n_cmp++; if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL bi_flush: got v=%b req=%b expected v=0 req=0", ir_valid, mem_req); end
        cycle();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_err++; $display("FAIL bi_target: got req=%b addr=%h expected req=1 addr=00000100", mem_req, mem_addr); end
        cycle();
        n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 32'h100 || ir_out !== 32'hA000_0100) begin
            n_err++; $display("FAIL bi_first: got v=%b pc=%h ir=%h expected v=1 pc=00000100 ir=a0000100", ir_valid, pc_out, ir_out);
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        auto_mem = 1'b0;
        mem_ack  = 1'b0;
        ir_ready = 1'b1;
        cycle();
        branch_en     = 1'b1;
        branch_target = 32'h200;
        for (int i = 2; i <= 4; i++) begin
            cycle();
            branch_en = 1'b0;
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ir_valid !== 1'b0) begin
                n_err++; $display("FAIL bw_hold c%0d: got req=%b addr=%h v=%b expected req=1 addr=00000000 v=0", i, mem_req, mem_addr, ir_valid);
            end
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        cycle();
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin n_err++; $display("FAIL bw_drop: got req=%b v=%b expected req=0 v=0", mem_req, ir_valid); end
        cycle();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL bw_target: got req=%b addr=%h v=%b expected req=1 addr=00000200 v=0", mem_req, mem_addr, ir_valid);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        cycle();
        mem_ack = 1'b0;
        n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 32'h200 || ir_out !== 32'h1234_5678) begin
            n_err++; $display("FAIL bw_first: got v=%b pc=%h ir=%h expected v=1 pc=00000200 ir=12345678", ir_valid, pc_out, ir_out);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_addr [4];
        logic [31:0] pc;
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset();
        ir_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (i % 2 == 1) begin
                pc = wrap_addr[(i - 1) / 2];
                n_cmp++; if (w_req !== 1'b1 || w_addr !== pc) begin n_err++; $display("FAIL wrap_req c%0d: got req=%b addr=%h expected req=1 addr=%h", i, w_req, w_addr, pc); end
            end else begin
                pc = wrap_addr[i / 2 - 1];
                n_cmp++; if (w_ir_valid !== 1'b1 || w_pc_out !== pc || w_ir_out !== 32'hA000_0000 + pc) begin
                    n_err++; $display("FAIL wrap_deliver c%0d: got v=%b pc=%h ir=%h expected v=1 pc=%h ir=%h", i, w_ir_valid, w_pc_out, w_ir_out, pc, 32'hA000_0000 + pc);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_mem = 1'b0;
        mem_ack  = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL rw_reset: got req=%b addr=%h v=%b expected req=0 addr=00000000 v=0", mem_req, mem_addr, ir_valid);
        end
        cycle();
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL rw_restart: got req=%b addr=%h v=%b expected req=1 addr=00000000 v=0", mem_req, mem_addr, ir_valid);
        end
        branch_en     = 1'b1;
        branch_target = 32'h300;
        cycle();
        branch_en = 1'b0;
        reset     = 1'b1;
        cycle();
        reset   = 1'b0;
        mem_ack = 1'b1;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL rd_reset: got req=%b addr=%h v=%b expected req=0 addr=00000000 v=0", mem_req, mem_addr, ir_valid);
        end
        cycle();
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL rd_restart: got req=%b addr=%h v=%b expected req=1 addr=00000000 v=0", mem_req, mem_addr, ir_valid);
        end
        cycle();
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rd_no_push: got v=%b expected 0", ir_valid); end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        auto_mem = 1'b1;
        reset    = 1'b1;
        mem_ack  = 1'b0;
        w_ack    = 1'b0;
        w_rdata  = 32'h0;
        test_reset();
        test_zero_wait();
        test_full();
        test_branch_idle();
        test_branch_wait();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
